// File: rtl/mem_pkg.sv
// Shared types and defaults for the multi-channel memory controller.
package mem_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_NUM_CH = 2;
  localparam int MAX_CH     = 8;
  localparam int CH_ID_W    = 3;
  // Response data field is sized for the widest supported word; WIDTH must not exceed it.
  localparam int RSP_DATA_W = 64;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  typedef struct packed {
    logic                  vld;
    logic [CH_ID_W-1:0]    chan;
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } rsp_t;

  function automatic logic [MAX_CH-1:0] chan_onehot(input logic [CH_ID_W-1:0] chan);
    chan_onehot = MAX_CH'(1) << chan;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter: grants the first valid channel at or above the pointer (with wrap)
// and moves the pointer past the winner whenever a grant is issued.
module mem_rr_arb #(
  parameter  int NUM_CH = 2,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] valid_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [ID_W-1:0]   grant_id_o
);

  localparam logic [ID_W:0] NCH = (ID_W + 1)'(NUM_CH);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] rot;
  logic              found;
  logic [ID_W:0]     idx;
  logic [ID_W:0]     nxt;

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned (no latches).
  always_comb begin
    rot   = NUM_CH'({valid_i, valid_i} >> ptr_q);
    found = 1'b0;
    idx   = '0;
    // Descending scan: the last hit is the smallest offset from the pointer.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = {1'b0, ptr_q} + (ID_W + 1)'(i);
      end
    end
    if (idx >= NCH) idx = idx - NCH;
    grant_id_o = idx[ID_W-1:0];
    grant_o    = found ? (NUM_CH'(1) << grant_id_o) : '0;
    nxt        = idx + 1'b1;
    ptr_d      = ptr_q;
    if (found) ptr_d = (nxt >= NCH) ? '0 : nxt[ID_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// NUM_CH-port memory controller: round-robin access to one storage array, pipelined tagged reads.
// Optional MEM_RANGE_CHK_EN: out-of-range accesses answer with err_o=1 instead of being silent.
module mem_arb_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int READ_LAT   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic [NUM_CH-1:0]            wr_rd_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CH*WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [NUM_CH-1:0]            rvalid_o,
  output logic                         err_o
);

  localparam int                    ID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [NUM_CH-1:0]     grant;
  logic [ID_W-1:0]       grant_id;
  logic                  xfer;
  logic                  in_range;
  op_e                   sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [WIDTH-1:0]      rd_word;
  logic [WIDTH-1:0]      mem [DEPTH];
  rsp_t                  rsp_d;
  rsp_t                  rsp_q [READ_LAT];
  rsp_t                  rsp_out;
  logic [MAX_CH-1:0]     chan_oh;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  unused_bits;

  mem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign ready_o = grant;

  always_comb begin
    sel_op    = RD;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_op    = op_e'(wr_rd_i[c]);
        sel_addr  = addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[c*WIDTH +: WIDTH];
      end
    end
    xfer     = |grant;
    in_range = {1'b0, sel_addr} < DEPTH_L;
    rd_word  = in_range ? mem[sel_addr] : '0;

    rsp_d      = '0;
    rsp_d.chan = CH_ID_W'(grant_id);
    rsp_d.data = RSP_DATA_W'(rd_word);
`ifdef MEM_RANGE_CHK_EN
    // A dropped out-of-range write still owes its requester an error response.
    rsp_d.err  = !in_range;
    rsp_d.vld  = xfer && (sel_op == RD || !in_range);
`else
    rsp_d.vld  = xfer && (sel_op == RD);
`endif
  end

  // NOTE: the storage array has no reset; contents survive rst_i and only writes change them.
  always_ff @(posedge clk_i) begin
    if (xfer && sel_op == WR && in_range) mem[sel_addr] <= sel_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < READ_LAT; i++) rsp_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      rsp_q[0] <= rsp_d;
      for (int i = 1; i < READ_LAT; i++) rsp_q[i] <= rsp_q[i-1];
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rsp_out  = rsp_q[READ_LAT-1];
    chan_oh  = chan_onehot(rsp_out.chan);
    rvalid_o = rsp_out.vld ? chan_oh[NUM_CH-1:0] : '0;
    rdata_d  = rsp_out.vld ? rsp_out.data[WIDTH-1:0] : rdata_q;
    rdata_o  = rdata_d;
`ifdef MEM_RANGE_CHK_EN
    err_o    = rsp_out.vld && rsp_out.err;
`else
    err_o    = 1'b0;
`endif
  end

  // Spare struct and one-hot bits beyond this configuration's WIDTH/NUM_CH.
  assign unused_bits = ^{rsp_out.data >> WIDTH, chan_oh >> NUM_CH, rsp_out.err};

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Drives two controllers (DEPTH=64/READ_LAT=1 and DEPTH=48/READ_LAT=3) with shared stimulus and
// checks both every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_mem_arb_ctrl;

  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int AW  = 6;
  localparam int LAT [2] = '{1, 3};
  localparam int DEP [2] = '{64, 48};
`ifdef MEM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NCH-1:0]    valid;
  logic [NCH-1:0]    wr_rd;
  logic [NCH*AW-1:0] addr;
  logic [NCH*W-1:0]  wdata;
  logic [NCH-1:0]    rdy    [2];
  logic [NCH-1:0]    rvalid [2];
  logic [W-1:0]      rdata  [2];
  logic              err    [2];

  always #5 clk = ~clk;

  mem_arb_ctrl #(.WIDTH(W), .DEPTH(64), .NUM_CH(NCH), .READ_LAT(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy[0]), .wr_rd_i(wr_rd),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .err_o(err[0])
  );

  mem_arb_ctrl #(.WIDTH(W), .DEPTH(48), .NUM_CH(NCH), .READ_LAT(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy[1]), .wr_rd_i(wr_rd),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .err_o(err[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         cyc   = 0;
  int         m_ptr = 0;
  logic [W-1:0] m_mem [2][64];
  bit         e_v  [2][16];
  int         e_ch [2][16];
  logic [W-1:0] e_d [2][16];
  bit         e_e  [2][16];
  logic [W-1:0] m_rdata [2];

  function automatic int model_grant(input logic [NCH-1:0] v, input int ptr);
    for (int i = 0; i < NCH; i++) begin
      if (v[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0;
      for (int n = 0; n < 2; n++) begin
        m_rdata[n] = '0;
        for (int s = 0; s < 16; s++) e_v[n][s] = 1'b0;
      end
    end else begin
      int g;
      int a;
      int slot;
      bit inr;
      logic [W-1:0] d;
      cyc++;
      for (int n = 0; n < 2; n++) e_v[n][(cyc + 15) % 16] = 1'b0;
      g = model_grant(valid, m_ptr);
      if (g >= 0) begin
        a = int'(addr[g*AW +: AW]);
        d = wdata[g*W +: W];
        for (int n = 0; n < 2; n++) begin
          slot = (cyc + LAT[n] - 1) % 16;
          inr  = (a < DEP[n]);
          if (wr_rd[g]) begin
            if (inr) m_mem[n][a] = d;
            else if (CHK) begin
              e_v[n][slot] = 1'b1; e_ch[n][slot] = g; e_d[n][slot] = '0; e_e[n][slot] = 1'b1;
            end
          end else begin
            e_v[n][slot]  = 1'b1;
            e_ch[n][slot] = g;
            e_d[n][slot]  = inr ? m_mem[n][a] : '0;
            e_e[n][slot]  = CHK && !inr;
          end
        end
        m_ptr = (g + 1) % NCH;
      end
      for (int n = 0; n < 2; n++) begin
        if (e_v[n][cyc % 16]) m_rdata[n] = e_d[n][cyc % 16];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int g;
      int s;
      logic [NCH-1:0] er;
      g  = model_grant(valid, m_ptr);
      er = (g >= 0) ? (NCH'(1) << g) : '0;
      s  = cyc % 16;
      for (int n = 0; n < 2; n++) begin
        check($sformatf("model_ready[%0d]", n), rdy[n], er);
        check($sformatf("model_rvalid[%0d]", n), rvalid[n],
              e_v[n][s] ? (NCH'(1) << e_ch[n][s]) : '0);
        check($sformatf("model_rdata[%0d]", n), rdata[n], m_rdata[n]);
        check($sformatf("model_err[%0d]", n), err[n], e_v[n][s] && e_e[n][s]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    valid = '0; wr_rd = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_req(input int ch, input bit wr, input int a, input logic [W-1:0] d);
    valid[ch]         = 1'b1;
    wr_rd[ch]         = wr;
    addr[ch*AW +: AW] = AW'(a);
    wdata[ch*W +: W]  = d;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int ch, input bit wr, input int a, input logic [W-1:0] d);
    int waited = 0;
    set_req(ch, wr, a, d);
    @(negedge clk);
    while (!rdy[0][ch] && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("send_grant", rdy[0][ch], 1);
    @(posedge clk); #1;
    valid[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive_idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rvalid_a", rvalid[0], 0);
    check("rst_rdata_a", rdata[0], 0);
    check("rst_err_a", err[0], 0);
    check("rst_rvalid_b", rvalid[1], 0);
    check("rst_rdata_b", rdata[1], 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Preload: addr i holds 0x1000 + i*0x111, addr 47 holds 0x4747.
    for (int i = 0; i < 8; i++) send(i % 2, 1'b1, i, 16'h1000 + 16'(i) * 16'h0111);
    send(1, 1'b1, 47, 16'h4747);

    // Write then read-back on the next cycle.
    send(0, 1'b1, 5, 16'hA5A5);
    send(0, 1'b0, 5, '0);
    @(negedge clk);
    check("t1_rvalid_a", rvalid[0], 2'b01);
    check("t1_rdata_a", rdata[0], 16'hA5A5);
    repeat (4) @(posedge clk);
    #1;

    // Ch1 alone, back-to-back reads of addr 0..3.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_req(1, 1'b0, k, '0);
      else       drive_idle();
      @(negedge clk);
      if (k < 4) begin
        check("t3_ready_a", rdy[0], 2'b10);
        check("t3_ready_b", rdy[1], 2'b10);
      end
      if (k >= 1 && k <= 4) begin
        check("t3_rvalid_a", rvalid[0], 2'b10);
        check("t3_rdata_a", rdata[0], 32'h1000 + (k - 1) * 32'h111);
      end
      if (k >= 3 && k <= 6) begin
        check("t3_rvalid_b", rvalid[1], 2'b10);
        check("t3_rdata_b", rdata[1], 32'h1000 + (k - 3) * 32'h111);
      end
      @(posedge clk); #1;
    end

    // Both channels held valid: grants must alternate starting at ch0.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
      end else drive_idle();
      @(negedge clk);
      if (k < 4) check("t2_ready_a", rdy[0], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 1 && k <= 4) begin
        check("t2_rvalid_a", rvalid[0], ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        check("t2_rdata_a", rdata[0], ((k - 1) % 2 == 0) ? 16'h1111 : 16'h1222);
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset while a read is in flight in the 3-stage pipeline.
    send(0, 1'b0, 3, '0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_rvalid_b", rvalid[1], 0);
    check("t4_rst_rdata_b", rdata[1], 0);
    check("t4_rst_rdata_a", rdata[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t4_post_rvalid_a", rvalid[0], 0);
      check("t4_post_rvalid_b", rvalid[1], 0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3, '0);
    set_req(1, 1'b0, 2, '0);
    @(negedge clk);
    check("t4_ptr0_ready_a", rdy[0], 2'b01);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    @(negedge clk);
    check("t4_reread_rvalid_a", rvalid[0], 2'b01);
    check("t4_reread_rdata_a", rdata[0], 16'h1333);
    check("t4_ready_a", rdy[0], 2'b10);
    @(posedge clk); #1;
    drive_idle();
    repeat (4) @(posedge clk);
    #1;

    // Address 50: in range for the 64-deep instance, out of range for the 48-deep one.
    send(0, 1'b1, 50, 16'h1234);
    send(0, 1'b0, 50, '0);
    @(negedge clk);
    check("t5_rdata_a_50", rdata[0], 16'h1234);
    @(posedge clk); #1;
    send(0, 1'b0, 47, '0);
    @(negedge clk);
    check("t5_rdata_a_47", rdata[0], 16'h4747);
    check("t5_rvalid_b_50", rvalid[1], 2'b01);
    check("t5_rdata_b_50", rdata[1], 0);
    check("t5_err_b_50", err[1], CHK);
    repeat (2) @(negedge clk);
    check("t5_rvalid_b_47", rvalid[1], 2'b01);
    check("t5_rdata_b_47", rdata[1], 16'h4747);
    check("t5_err_b_47", err[1], 0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
